// File: rtl/seg7_pair_decoder.sv
// Decodes two active-low 7-segment buses into a committed two-digit value after a stability window.
// Optional SEGDEC_BLANK_TENS_EN: an all-off tens digit decodes as 0 (leading-zero suppression).
module seg7_pair_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [6:0]             i_Segment1_n,
    input  logic [6:0]             i_Segment2_n,
    output logic [3:0]             o_Tens,
    output logic [3:0]             o_Ones,
    output logic [6:0]             o_Value,
    output logic                   o_Valid,
    output logic                   o_Update,
    output logic                   o_Illegal,
    output logic [COUNT_WIDTH-1:0] o_Update_Count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

`ifdef SEGDEC_BLANK_TENS_EN
    localparam logic BLANK_TENS_OK = 1'b1;
`else
    localparam logic BLANK_TENS_OK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        STABLE
    } state_t;

    state_t           state, state_nxt;
    logic [13:0]      sample_n_p0;
    logic [CNT_W-1:0] stable_cnt, stable_cnt_nxt;
    logic             changed;
    logic             eval;
    logic [4:0]       tens_dec, ones_dec;
    logic             both_legal;
    logic [6:0]       value_calc;

    // Returns {legal, digit}; seg is active-high A..G.
    function automatic logic [4:0] decode_digit(input logic [6:0] seg, input logic blank_ok);
        logic [4:0] res;
        case (seg)
            7'b1111110: res = {1'b1, 4'd0};
            7'b0110000: res = {1'b1, 4'd1};
            7'b1101101: res = {1'b1, 4'd2};
            7'b1111001: res = {1'b1, 4'd3};
            7'b0110011: res = {1'b1, 4'd4};
            7'b1011011: res = {1'b1, 4'd5};
            7'b1011111: res = {1'b1, 4'd6};
            7'b1110000: res = {1'b1, 4'd7};
            7'b1111111: res = {1'b1, 4'd8};
            7'b1111011: res = {1'b1, 4'd9};
            7'b0000000: res = {blank_ok, 4'd0};
            default:    res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    function automatic logic [6:0] calc_value(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t7;
        t7 = {3'b000, tens};
        return (t7 << 3) + (t7 << 1) + {3'b000, ones};
    endfunction

    assign changed    = ({i_Segment1_n, i_Segment2_n} != sample_n_p0);
    assign tens_dec   = decode_digit(~sample_n_p0[13:7], BLANK_TENS_OK);
    assign ones_dec   = decode_digit(~sample_n_p0[6:0], 1'b0);
    assign both_legal = tens_dec[4] & ones_dec[4];
    assign value_calc = calc_value(tens_dec[3:0], ones_dec[3:0]);

    always_comb begin
        stable_cnt_nxt = stable_cnt;
        if (changed) begin
            stable_cnt_nxt = CNT_W'(1);
        end else if (stable_cnt != CNT_MAX) begin
            stable_cnt_nxt = stable_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        eval      = 1'b0;
        case (state)
            IDLE:   state_nxt = SETTLE;
            SETTLE: begin
                if (stable_cnt == CNT_MAX) begin
                    eval      = 1'b1;
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                // A restarted count means the sample moved since the last evaluation.
                if (stable_cnt != CNT_MAX) begin
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: raw sample capture, stability tracking and FSM state.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= IDLE;
            sample_n_p0 <= '1;
            stable_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            sample_n_p0 <= {i_Segment1_n, i_Segment2_n};
            stable_cnt  <= stable_cnt_nxt;
        end
    end

    // Stage p1: commit of evaluated value and event pulses.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Tens         <= '0;
            o_Ones         <= '0;
            o_Value        <= '0;
            o_Valid        <= 1'b0;
            o_Update       <= 1'b0;
            o_Illegal      <= 1'b0;
            o_Update_Count <= '0;
        end else begin
            o_Update  <= 1'b0;
            o_Illegal <= 1'b0;
            if (eval) begin
                if (!both_legal) begin
                    o_Illegal <= 1'b1;
                end else if (!o_Valid || (value_calc != o_Value)) begin
                    o_Tens   <= tens_dec[3:0];
                    o_Ones   <= ones_dec[3:0];
                    o_Value  <= value_calc;
                    o_Valid  <= 1'b1;
                    o_Update <= 1'b1;
                    if (o_Update_Count != {COUNT_WIDTH{1'b1}}) begin
                        o_Update_Count <= o_Update_Count + COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed plus randomized bench for seg7_pair_decoder against a run-length reference model.
module tb_seg7_pair_decoder;

    localparam int S  = 4;
    localparam int CW = 4;
    localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011};

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg1_n, seg2_n;
    logic [3:0]    tens, ones;
    logic [6:0]    value;
    logic          valid, update, illegal;
    logic [CW-1:0] upd_count;

    seg7_pair_decoder #(.STABLE_CYCLES(S), .COUNT_WIDTH(CW)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Segment1_n(seg1_n), .i_Segment2_n(seg2_n),
        .o_Tens(tens), .o_Ones(ones), .o_Value(value), .o_Valid(valid),
        .o_Update(update), .o_Illegal(illegal), .o_Update_Count(upd_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int update_pulses = 0;

    // Reference model state
    logic [3:0]    m_tens, m_ones;
    logic [6:0]    m_value;
    logic          m_valid, m_upd, m_ill;
    logic [CW-1:0] m_cnt;
    logic [13:0]   last_in;
    int            run_len;
    bit            fresh;

    function automatic int dec(input logic [6:0] p, input bit is_tens);
        for (int d = 0; d < 10; d++) if (PAT[d] == p) return d;
`ifdef SEGDEC_BLANK_TENS_EN
        if (is_tens && p == 7'b0000000) return 0;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_tens = 0; m_ones = 0; m_value = 0; m_valid = 0; m_upd = 0; m_ill = 0; m_cnt = 0;
        run_len = 0; fresh = 1; last_in = '1;
    endtask

    // One clock edge: a run of identical samples is judged once, on the edge after it reaches S.
    task automatic model_edge(input logic r, input logic [13:0] in_n);
        int t, o, v;
        if (r) begin
            model_reset();
            return;
        end
        m_upd = 0;
        m_ill = 0;
        if (run_len == S) begin
            t = dec(~last_in[13:7], 1'b1);
            o = dec(~last_in[6:0], 1'b0);
            if (t < 0 || o < 0) begin
                m_ill = 1;
            end else begin
                v = 10 * t + o;
                if (!m_valid || v != int'(m_value)) begin
                    m_tens = 4'(t); m_ones = 4'(o); m_value = 7'(v); m_valid = 1; m_upd = 1;
                    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
                end
            end
        end
        if (fresh || in_n != last_in) run_len = 1;
        else if (run_len <= S) run_len++;
        last_in = in_n;
        fresh = 0;
    endtask

    task automatic check_all();
        vectors++;
        assert (tens === m_tens) else begin
            miscompares++; $error("FAIL tens t=%0t got %0d expected %0d", $time, tens, m_tens);
        end
        assert (ones === m_ones) else begin
            miscompares++; $error("FAIL ones t=%0t got %0d expected %0d", $time, ones, m_ones);
        end
        assert (value === m_value) else begin
            miscompares++; $error("FAIL value t=%0t got %0d expected %0d", $time, value, m_value);
        end
        assert (valid === m_valid) else begin
            miscompares++; $error("FAIL valid t=%0t got %b expected %b", $time, valid, m_valid);
        end
        assert (update === m_upd) else begin
            miscompares++; $error("FAIL update t=%0t got %b expected %b", $time, update, m_upd);
        end
        assert (illegal === m_ill) else begin
            miscompares++; $error("FAIL illegal t=%0t got %b expected %b", $time, illegal, m_ill);
        end
        assert (upd_count === m_cnt) else begin
            miscompares++; $error("FAIL upd_count t=%0t got %0d expected %0d", $time, upd_count, m_cnt);
        end
        if (update) update_pulses++;
    endtask

    // Drive active-high patterns for one clock edge, then compare against the model.
    task automatic step(input logic [6:0] t_pat, input logic [6:0] o_pat, input logic r);
        rst    = r;
        seg1_n = ~t_pat;
        seg2_n = ~o_pat;
        @(posedge clk);
        #1;
        model_edge(r, {~t_pat, ~o_pat});
        check_all();
    endtask

    task automatic hold(input logic [6:0] t_pat, input logic [6:0] o_pat, input int n);
        for (int i = 0; i < n; i++) step(t_pat, o_pat, 1'b0);
    endtask

    initial begin
        int r, h, a, b;
        logic [6:0] rt, ro;
        model_reset();
        rst = 1'b1; seg1_n = '1; seg2_n = '1;
        step(7'b0, 7'b0, 1'b1);
        step(7'b0, 7'b0, 1'b1);

        // All segments off: a single illegal pulse, never an update.
        hold(7'b0, 7'b0, 20);

        // 42 committed four edges after it first appears.
        hold(PAT[4], PAT[2], 8);

        // Three-cycle glitch to 57 is rejected; 42 is re-evaluated with no change.
        hold(PAT[5], PAT[7], 3);
        hold(PAT[4], PAT[2], 8);

        // Illegal ones digit.
        hold(PAT[0], 7'b0000001, 8);

        // Sweep 0..99 to drive the update counter into saturation.
        update_pulses = 0;
        for (int v = 0; v < 100; v++) hold(PAT[v / 10], PAT[v % 10], 6);
        vectors++;
        assert (update_pulses == 100) else begin
            miscompares++; $error("FAIL sweep_updates got %0d expected 100", update_pulses);
        end

`ifdef SEGDEC_BLANK_TENS_EN
        hold(7'b0, PAT[7], 6);
`endif

        // Reset two cycles into a settle.
        hold(PAT[6], PAT[3], 2);
        step(PAT[6], PAT[3], 1'b1);
        hold(PAT[6], PAT[3], 6);

        // Randomized runs: legal pairs, random segment noise, short glitches and resets.
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            h = $urandom_range(1, 6);
            a = $urandom_range(0, 9);
            b = $urandom_range(0, 9);
            rt = 7'($urandom);
            ro = 7'($urandom);
            if (r < 6)       hold(PAT[a], PAT[b], h);
            else if (r == 6) hold(rt, ro, h);
            else if (r == 7) hold(PAT[a], ro, h);
            else if (r == 8) hold(rt, PAT[b], $urandom_range(1, 3));
            else             step(PAT[a], PAT[b], 1'b1);
        end
        hold(PAT[9], PAT[9], 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
